load_store_unit: RTL and testbench

Executes the memory operations flagged by the CPU decode stage: mem_read, mem_write, mem_width, mem_zero_extend and mem_fence. It turns each load or store into a single-outstanding transaction on the 32-bit data bus, with a ready handshake. It performs alignment checks, byte-lane steering and sign/zero extension, and returns load data for register writeback. It sits between execute (which supplies the address and store data) and writeback, and stalls the pipeline while a transaction is in flight.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between execute and writeback.
// Performs alignment checks, store byte-lane steering, load sign/zero extension and
// a bus wait timeout. busy_out stalls the pipeline while an access is in flight.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_fence_in,
    input  logic [1:0]      mem_width_in,
    input  logic            mem_zero_extend_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [4:0]      rd_in,
    output logic            busy_out,
    output logic [XLEN-1:0] bus_addr_out,
    output logic            bus_read_out,
    output logic            bus_write_out,
    output logic [XLEN-1:0] bus_wdata_out,
    output logic [3:0]      bus_wmask_out,
    input  logic [XLEN-1:0] bus_rdata_in,
    input  logic            bus_ready_in,
    input  logic            bus_fault_in,
    output logic            done_out,
    output logic            rd_write_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] rd_value_out,
    output logic            exc_misaligned_out,
    output logic            exc_fault_out
);
    // state | meaning
    // IDLE  | waiting for a memory instruction from decode
    // BUS   | request held on the data bus until ready or timeout
    // RESP  | one-cycle completion: done, writeback strobe, exception flags
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

    // Counter only needs to reach TIMEOUT-1; a TIMEOUT of 0 disables the check entirely.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            is_load_q;
    logic [1:0]      width_q;
    logic            zext_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wmask_q;
    logic [XLEN-1:0] rd_value_q;
    logic            exc_mis_q;
    logic            exc_fault_q;
    logic [CW-1:0]   wait_q;

    logic            issue_mem;
    logic            issue_fence;
    logic            misaligned;
    logic            timeout_hit;
    logic [XLEN-1:0] steer_wdata;
    logic [3:0]      steer_wmask;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext;

    // Decode the issuing instruction; read wins over write, a fence alone has no bus phase.
    always_comb begin
        issue_mem   = valid_in && (mem_read_in || mem_write_in);
        issue_fence = valid_in && mem_fence_in && !mem_read_in && !mem_write_in;
        timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
        case (mem_width_in)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr_in[0];
            2'd2:    misaligned = |addr_in[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Replicate store data into every lane and enable only the addressed bytes.
    always_comb begin
        case (mem_width_in)
            2'd0: begin
                steer_wdata = {4{wdata_in[7:0]}};
                steer_wmask = 4'b0001 << addr_in[1:0];
            end
            2'd1: begin
                steer_wdata = {2{wdata_in[15:0]}};
                steer_wmask = 4'b0011 << addr_in[1:0];
            end
            default: begin
                steer_wdata = wdata_in;
                steer_wmask = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        lane_b = bus_rdata_in[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
        case (width_q)
            2'd0:    load_ext = zext_q ? {{(XLEN-8){1'b0}}, lane_b}
                                       : {{(XLEN-8){lane_b[7]}}, lane_b};
            2'd1:    load_ext = zext_q ? {{(XLEN-16){1'b0}}, lane_h}
                                       : {{(XLEN-16){lane_h[15]}}, lane_h};
            default: load_ext = bus_rdata_in;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_mem) begin
                    state_d = misaligned ? S_RESP : S_BUS;
                end else if (issue_fence) begin
                    state_d = S_RESP;
                end
            end
            S_BUS: begin
                if (bus_ready_in || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_out      = (state_q != S_IDLE);
        bus_read_out  = (state_q == S_BUS) && is_load_q;
        bus_write_out = (state_q == S_BUS) && !is_load_q;
        done_out      = (state_q == S_RESP);
        rd_write_out  = (state_q == S_RESP) && is_load_q && !exc_mis_q && !exc_fault_q
                        && (rd_q != 5'd0);
    end

    // Access latch, wait counter and result registers; flags only change when entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_load_q   <= 1'b0;
            width_q     <= 2'd0;
            zext_q      <= 1'b0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= 4'd0;
            rd_value_q  <= '0;
            exc_mis_q   <= 1'b0;
            exc_fault_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_mem) begin
                        is_load_q <= mem_read_in;
                        width_q   <= mem_width_in;
                        zext_q    <= mem_zero_extend_in;
                        off_q     <= addr_in[1:0];
                        rd_q      <= rd_in;
                        addr_q    <= {addr_in[XLEN-1:2], 2'b00};
                        wdata_q   <= steer_wdata;
                        wmask_q   <= steer_wmask;
                        wait_q    <= '0;
                        if (misaligned) begin
                            exc_mis_q   <= 1'b1;
                            exc_fault_q <= 1'b0;
                        end
                    end else if (issue_fence) begin
                        is_load_q   <= 1'b0;
                        rd_q        <= rd_in;
                        exc_mis_q   <= 1'b0;
                        exc_fault_q <= 1'b0;
                    end
                end
                S_BUS: begin
                    if (bus_ready_in) begin
                        exc_mis_q   <= 1'b0;
                        exc_fault_q <= bus_fault_in;
                        if (is_load_q) begin
                            rd_value_q <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        exc_mis_q   <= 1'b0;
                        exc_fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_addr_out       = addr_q;
    assign bus_wdata_out      = wdata_q;
    assign bus_wmask_out      = wmask_q;
    assign rd_out             = rd_q;
    assign rd_value_out       = rd_value_q;
    assign exc_misaligned_out = exc_mis_q;
    assign exc_fault_out      = exc_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the memory access rules.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, mem_fence_in = 1'b0;
    logic [1:0]  mem_width_in = 2'd0;
    logic        mem_zero_extend_in = 1'b0;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] bus_rdata_in = '0;
    logic        bus_ready_in = 1'b0, bus_fault_in = 1'b0;

    logic        busy_out, bus_read_out, bus_write_out, done_out, rd_write_out;
    logic        exc_misaligned_out, exc_fault_out;
    logic [31:0] bus_addr_out, bus_wdata_out, rd_value_out;
    logic [3:0]  bus_wmask_out;
    logic [4:0]  rd_out;

    logic        t_busy, t_bus_read, t_bus_write, t_done, t_rd_write, t_exc_mis, t_exc_fault;
    logic [31:0] t_bus_addr, t_bus_wdata, t_rd_value;
    logic [3:0]  t_bus_wmask;
    logic [4:0]  t_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_fence_in(mem_fence_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_in(rd_in), .busy_out(busy_out), .bus_addr_out(bus_addr_out),
        .bus_read_out(bus_read_out), .bus_write_out(bus_write_out),
        .bus_wdata_out(bus_wdata_out), .bus_wmask_out(bus_wmask_out),
        .bus_rdata_in(bus_rdata_in), .bus_ready_in(bus_ready_in), .bus_fault_in(bus_fault_in),
        .done_out(done_out), .rd_write_out(rd_write_out), .rd_out(rd_out),
        .rd_value_out(rd_value_out), .exc_misaligned_out(exc_misaligned_out),
        .exc_fault_out(exc_fault_out)
    );

    // Second instance with a short timeout and a bus that never answers.
    load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_fence_in(mem_fence_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_in(rd_in), .busy_out(t_busy), .bus_addr_out(t_bus_addr),
        .bus_read_out(t_bus_read), .bus_write_out(t_bus_write),
        .bus_wdata_out(t_bus_wdata), .bus_wmask_out(t_bus_wmask),
        .bus_rdata_in(bus_rdata_in), .bus_ready_in(1'b0), .bus_fault_in(bus_fault_in),
        .done_out(t_done), .rd_write_out(t_rd_write), .rd_out(t_rd),
        .rd_value_out(t_rd_value), .exc_misaligned_out(t_exc_mis),
        .exc_fault_out(t_exc_fault)
    );

    // Issue one instruction (called at a negedge in an IDLE cycle) and follow it to
    // completion, checking every cycle against the access-rule model. Returns at the
    // negedge of the first IDLE cycle after RESP.
    task automatic run_op(input logic rd_f, input logic wr_f, input logic fn_f,
                          input logic [1:0] w, input logic zx, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic flt, input int waits);
        logic        mem, load, mis, bus, e_flt, e_rdw;
        logic [31:0] e_addr, e_wdata, e_val, sh;
        logic [3:0]  e_mask;
        int          off;
        mem    = rd_f | wr_f;
        load   = rd_f;
        off    = int'(a[1:0]);
        mis    = mem && (w == 2'd3 || (w == 2'd1 && a[0]) || (w == 2'd2 && off != 0));
        bus    = mem && !mis;
        e_flt  = bus && flt;
        e_rdw  = load && !mis && !e_flt && (rd != 5'd0);
        e_addr = a & 32'hFFFF_FFFC;
        sh     = rdata >> (8 * off);
        case (w)
            2'd0: begin
                e_wdata = {4{wd[7:0]}};
                e_mask  = 4'(1 << off);
                e_val   = sh & 32'hFF;
                if (!zx && e_val >= 32'h80) e_val = e_val - 32'h100;
            end
            2'd1: begin
                e_wdata = {2{wd[15:0]}};
                e_mask  = 4'(3 << off);
                e_val   = sh & 32'hFFFF;
                if (!zx && e_val >= 32'h8000) e_val = e_val - 32'h10000;
            end
            default: begin
                e_wdata = wd;
                e_mask  = 4'hF;
                e_val   = rdata;
            end
        endcase

        valid_in = 1'b1; mem_read_in = rd_f; mem_write_in = wr_f; mem_fence_in = fn_f;
        mem_width_in = w; mem_zero_extend_in = zx; addr_in = a; wdata_in = wd; rd_in = rd;
        bus_ready_in = 1'($urandom);
        bus_fault_in = 1'($urandom);
        bus_rdata_in = $urandom;
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_fence_in = 1'b0;

        if (!(mem || fn_f)) begin
            checks++;
            if (busy_out !== 1'b0 || done_out !== 1'b0) begin
                errors++;
                $display("FAIL ignored_issue: busy=%0b done=%0b expected 0 0", busy_out, done_out);
            end
            return;
        end

        if (bus) begin
            for (int i = 0; i <= waits; i++) begin
                checks++;
                if (busy_out !== 1'b1 || done_out !== 1'b0) begin
                    errors++;
                    $display("FAIL bus_phase cycle %0d: busy=%0b done=%0b expected 1 0", i, busy_out, done_out);
                end
                checks++;
                if (bus_read_out !== load || bus_write_out !== !load) begin
                    errors++;
                    $display("FAIL bus_request cycle %0d: rd=%0b wr=%0b expected %0b %0b", i, bus_read_out, bus_write_out, load, !load);
                end
                checks++;
                if (bus_addr_out !== e_addr) begin
                    errors++;
                    $display("FAIL bus_addr cycle %0d: got %h expected %h", i, bus_addr_out, e_addr);
                end
                if (!load) begin
                    checks++;
                    if (bus_wdata_out !== e_wdata || bus_wmask_out !== e_mask) begin
                        errors++;
                        $display("FAIL store_steer cycle %0d: data=%h mask=%b expected %h %b", i, bus_wdata_out, bus_wmask_out, e_wdata, e_mask);
                    end
                end
                bus_ready_in = (i == waits);
                bus_rdata_in = (i == waits) ? rdata : $urandom;
                bus_fault_in = (i == waits) ? flt : 1'($urandom);
                @(negedge clk);
            end
            bus_ready_in = 1'($urandom);
            bus_fault_in = 1'($urandom);
        end

        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL resp_done: done=%0b busy=%0b expected 1 1", done_out, busy_out);
        end
        checks++;
        if (bus_read_out !== 1'b0 || bus_write_out !== 1'b0) begin
            errors++;
            $display("FAIL resp_no_request: rd=%0b wr=%0b expected 0 0", bus_read_out, bus_write_out);
        end
        checks++;
        if (rd_write_out !== e_rdw || rd_out !== rd) begin
            errors++;
            $display("FAIL writeback: rd_write=%0b rd=%0d expected %0b %0d", rd_write_out, rd_out, e_rdw, rd);
        end
        checks++;
        if (exc_misaligned_out !== mis || exc_fault_out !== e_flt) begin
            errors++;
            $display("FAIL exceptions: mis=%0b fault=%0b expected %0b %0b", exc_misaligned_out, exc_fault_out, mis, e_flt);
        end
        if (load && !mis && !e_flt) begin
            checks++;
            if (rd_value_out !== e_val) begin
                errors++;
                $display("FAIL load_value: got %h expected %h (w=%0d zx=%0b off=%0d)", rd_value_out, e_val, w, zx, off);
            end
        end
        @(negedge clk);
        bus_ready_in = 1'b0;
        bus_fault_in = 1'b0;
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: done=%0b busy=%0b expected 0 0", done_out, busy_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_out, bus_read_out, bus_write_out, done_out, rd_write_out,
             exc_misaligned_out, exc_fault_out} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%0b rd=%0b wr=%0b done=%0b rdw=%0b mis=%0b flt=%0b expected all 0",
                     busy_out, bus_read_out, bus_write_out, done_out, rd_write_out, exc_misaligned_out, exc_fault_out);
        end
        checks++;
        if (bus_addr_out !== 32'd0 || bus_wdata_out !== 32'd0 || bus_wmask_out !== 4'd0 ||
            rd_out !== 5'd0 || rd_value_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h mask=%b rd=%0d val=%h expected all 0",
                     bus_addr_out, bus_wdata_out, bus_wmask_out, rd_out, rd_value_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        valid_in = 1'b1; mem_read_in = 1'b1; mem_width_in = 2'd2; addr_in = 32'h40; rd_in = 5'd3;
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t_bus_read !== 1'b1 || t_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: req=%0b done=%0b expected 1 0", i, t_bus_read, t_done);
            end
            @(negedge clk);
        end
        checks++;
        if (t_bus_read !== 1'b0 || t_done !== 1'b1 || t_exc_fault !== 1'b1 || t_rd_write !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: req=%0b done=%0b fault=%0b rdw=%0b expected 0 1 1 0",
                     t_bus_read, t_done, t_exc_fault, t_rd_write);
        end
        // The main instance is still waiting on the bus; clear both.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_signed_byte();
        run_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd5, 32'h8000_0000, 1'b0, 2);
        checks++;
        if (rd_value_out !== 32'hFFFF_FF80 || bus_addr_out !== 32'h1000) begin
            errors++;
            $display("FAIL lb_value: val=%h addr=%h expected ffffff80 00001000", rd_value_out, bus_addr_out);
        end
        run_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd5, 32'h8000_0000, 1'b0, 0);
        checks++;
        if (rd_value_out !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_value: got %h expected 00000080", rd_value_out);
        end
    endtask

    task automatic test_half_store();
        run_op(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'hABCD_1234, 5'd7, 32'h0, 1'b0, 0);
        checks++;
        if (bus_wdata_out !== 32'h1234_1234 || bus_wmask_out !== 4'b1100) begin
            errors++;
            $display("FAIL sh_steer: data=%h mask=%b expected 12341234 1100", bus_wdata_out, bus_wmask_out);
        end
    endtask

    task automatic test_wait_states();
        run_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_5A5C, 32'h0, 5'd9, 32'hDEAD_BEEF, 1'b0, 4);
        run_op(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_5A5D, 32'h0000_00C3, 5'd0, 32'h0, 1'b0, 4);
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd4, 32'h0, 1'b0, 0);
        run_op(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 5'd4, 32'h0, 1'b0, 0);
        checks++;
        if (exc_misaligned_out !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_hold: got %0b expected 1", exc_misaligned_out);
        end
        run_op(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 0);
    endtask

    task automatic test_bus_fault();
        run_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd12, 32'h1111_2222, 1'b1, 1);
        run_op(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4004, 32'h5555_AAAA, 5'd12, 32'h0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_bus();
        valid_in = 1'b1; mem_read_in = 1'b1; mem_width_in = 2'd2; addr_in = 32'h7000; rd_in = 5'd6;
        bus_ready_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0;
        checks++;
        if (bus_read_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req: got %0b expected 1", bus_read_out);
        end
        reset = 1'b1;
        bus_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_out, bus_read_out, bus_write_out, done_out, rd_write_out} !== 5'd0 ||
            bus_addr_out !== 32'd0 || rd_out !== 5'd0 || rd_value_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%0b rd=%0b done=%0b addr=%h rd_out=%0d val=%h expected all 0",
                     busy_out, bus_read_out, done_out, bus_addr_out, rd_out, rd_value_out);
        end
        reset = 1'b0;
        bus_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done=%0b busy=%0b expected 0 0", done_out, busy_out);
        end
        run_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 5'd0, 32'h0BAD_F00D, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        int          sel;
        logic        rd_f, wr_f, fn_f;
        logic [1:0]  w;
        for (int n = 0; n < 120; n++) begin
            sel  = $urandom_range(0, 9);
            rd_f = (sel < 4) || (sel == 7);
            wr_f = (sel >= 4 && sel <= 7);
            fn_f = (sel == 8) || ($urandom_range(0, 7) == 0);
            w    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_op(rd_f, wr_f, fn_f, w, 1'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_signed_byte();
        test_half_store();
        test_wait_states();
        test_misaligned();
        test_bus_fault();
        test_reset_mid_bus();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
